// File: rtl/freq_meter.sv
// Gated frequency meter.
// Counts rising edges of an asynchronous input over a fixed window of
// GateCycles clock cycles and publishes the count once per window.
// Windows run back to back while enable is high, so every input edge
// lands in exactly one window.
module freq_meter #(
    parameter int FrecIn     = 25000000,
    parameter int GateCycles = 25000000,
    parameter int CountWidth = 32
) (
    input  logic                  clockIn,
    input  logic                  resetN,
    input  logic                  enable,
    input  logic                  sigIn,
    output logic [CountWidth-1:0] freqOut,
    output logic                  freqValid,
    output logic                  overflow,
    output logic                  busy
);

    localparam int GW = (GateCycles > 1) ? $clog2(GateCycles) : 1;
    localparam logic [GW-1:0]         GATE_LAST = GW'(GateCycles - 1);
    localparam logic [CountWidth-1:0] CNT_MAX   = '1;

    // A window shorter than two cycles has no room for a terminal cycle.
    if (GateCycles < 2 || FrecIn < 1) begin : g_param_check
        $error("freq_meter: GateCycles must be >= 2 and FrecIn positive");
    end

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_s1;
    logic                    r_s2;
    logic                    r_s3;
    logic [GW-1:0]           r_gate_cnt;
    logic [CountWidth-1:0]   r_edge_cnt;
    logic                    r_ovf_acc;
    logic [CountWidth-1:0]   r_freq;
    logic                    r_valid;
    logic                    r_overflow;
    logic                    r_busy;

    logic                    w_edge;
    logic                    w_terminal;
    logic                    w_sat_hit;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CountWidth-1:0] sat_add(
        input logic [CountWidth-1:0] a,
        input logic                  b
    );
        if (b && (a == CNT_MAX)) begin
            sat_add = a;
        end else begin
            sat_add = a + CountWidth'(b);
        end
    endfunction

    assign w_edge     = r_s2 & ~r_s3;
    assign w_terminal = (r_gate_cnt == GATE_LAST);
    assign w_sat_hit  = w_edge & (r_edge_cnt == CNT_MAX);

    // Two-flop synchronizer plus a history flop for rising-edge detection; runs in every state.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sigIn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Window control FSM: gate counter, edge counter and registered result outputs.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
            r_freq     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_ovf_acc  <= 1'b0;
                    if (enable) begin
                        r_state <= ST_MEASURE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (!enable) begin
                        // Abort: partial count is discarded, last result is kept.
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_acc  <= 1'b0;
                    end else if (w_terminal) begin
                        // Edge arriving in the terminal cycle still belongs to this window.
                        r_state    <= ST_MEASURE;
                        r_busy     <= 1'b1;
                        r_freq     <= sat_add(r_edge_cnt, w_edge);
                        r_overflow <= r_ovf_acc | w_sat_hit;
                        r_valid    <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_acc  <= 1'b0;
                    end else begin
                        r_state    <= ST_MEASURE;
                        r_busy     <= 1'b1;
                        r_gate_cnt <= r_gate_cnt + GW'(1);
                        r_edge_cnt <= sat_add(r_edge_cnt, w_edge);
                        r_ovf_acc  <= r_ovf_acc | w_sat_hit;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_ovf_acc  <= 1'b0;
                end
            endcase
        end
    end

    assign freqOut   = r_freq;
    assign freqValid = r_valid;
    assign overflow  = r_overflow;
    assign busy      = r_busy;

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Gated frequency meter. It counts rising edges of an asynchronous input signal over a fixed window of clockIn cycles and reports the count once per window. It is the measuring counterpart of the frequency divider. It is used to verify divider outputs on-board and to measure external square waves. With GateCycles = FrecIn the result reads directly in Hz.

Parameters:
FrecIn, 25000000, clockIn frequency in Hz (documentation/scaling only)
GateCycles, 25000000, measurement window length in clockIn cycles; must be ≥ 2
CountWidth, 32, width of the edge counter and result

Ports:
clockIn  input  1  system clock; all logic on its rising edge
resetN  input  1  reset, asynchronous, active-low
enable  input  1  1 = run back-to-back windows; 0 = abort/idle
sigIn  input  1  asynchronous signal under measurement
freqOut  output  CountWidth  edge count of last completed window
freqValid  output  1  one-cycle pulse when freqOut updates
overflow  output  1  last completed window saturated
busy  output  1  high while a window is in progress

Behaviour:
- Reset (resetN=0, immediate, asynchronous):
  - state=IDLE; gateCnt, edgeCnt, ovfAcc and the synchronizer flops cleared to 0.
  - Outputs: freqOut=0, freqValid=0, overflow=0, busy=0.
- Input conditioning:
  - sigIn passes through a 2-flop synchronizer (s1, s2), then a third flop s3.
  - edge = s2 & ~s3.
  - The chain runs in every state; edges count only in MEASURE.
  - Input-to-edge latency is 2 cycles.
  - Correct counting is guaranteed for sigIn high and low phases each ≥ 2 clockIn cycles, i.e. ≤ FrecIn/4 at 50% duty.
- FSM, two states:
  - IDLE: busy=0, counters held at 0. If enable=1, go to MEASURE on the next edge with gateCnt=0, edgeCnt=0, ovfAcc=0.
  - MEASURE: busy=1; gateCnt increments each cycle.
    - On edge, edgeCnt increments. If edgeCnt is already 2^CountWidth−1, it holds and ovfAcc is set.
    - Terminal cycle (gateCnt == GateCycles−1, enable=1):
      - freqOut <= edgeCnt + edge, saturated; overflow <= ovfAcc or saturation in this cycle.
      - freqValid <= 1 for exactly one cycle.
      - gateCnt, edgeCnt and ovfAcc clear; state stays MEASURE.
    - The next window starts with no dead cycle, so every window is exactly GateCycles cycles and every edge lands in exactly one window.
    - enable=0 in any MEASURE cycle, including the terminal one: go to IDLE next cycle. No freqValid. Counters clear. freqOut and overflow hold their previous values.
- freqValid rises on the clock edge that ends the terminal cycle. The first pulse comes GateCycles cycles after MEASURE entry.
- freqOut and overflow change only together with freqValid, or on reset.
- gateCnt width is ceil(log2(GateCycles)). It never exceeds GateCycles−1.
- resetN asserted mid-window discards the partial count. After release the block returns to IDLE and re-enters MEASURE if enable=1.

Test Plan (GateCycles=100, CountWidth=8 unless stated):
1. resetN=0 with sigIn toggling and enable=1 → freqOut=0, freqValid=0, overflow=0, busy=0. After release, busy=1 one cycle later.
2. sigIn period 10 cycles (5/5), enable=1 for 5 windows → freqValid pulses exactly every 100 cycles, one cycle wide. freqOut=10 each window after the first; overflow=0.
3. sigIn held constant 1 → each window freqOut=0 with freqValid pulse. The single 0→1 transition before enable is not counted.
4. CountWidth=4, sigIn period 4 (25 edges/window) → freqOut=15, overflow=1. Switch to period 10 → next full window freqOut=10, overflow=0.
5. After a result of 10, drop enable at gateCnt=50 → busy=0 next cycle, no freqValid, freqOut stays 10. Re-enable → first freqValid exactly 100 cycles after MEASURE entry.
6. Pulse resetN low at gateCnt=70 → all outputs 0 immediately. After release with sigIn period 20 → first result freqOut=5.
